imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle MIPS core.
- Receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction-memory write port.
- Holds the core in reset until the whole program has been written, then releases it.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; depth DEPTH = 2^ADDR_W words.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- start  input  1  one-cycle load request; sampled in IDLE or RUN.
- len  input  ADDR_W+1  number of words to load; sampled on accepted start.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  word to write.
- cpu_rst  output  1  active-high reset driven to the processor's rst.
- busy  output  1  load in progress.
- done  output  1  program loaded, core running.
- err  output  1  last start rejected.

Behaviour:
- All outputs registered. rst==0 at a clock edge gives:
  - state IDLE, cpu_rst=1, byte_ready=0, imem_we=0;
  - imem_addr=0, imem_wdata=0;
  - busy=0, done=0, err=0;
  - byte_cnt=0, word_cnt=0.
- rst overrides everything, including a load in progress. A partially written program is abandoned and cpu_rst returns to 1.
- States: IDLE, RECV, WRITE, RUN.
- IDLE:
  - cpu_rst=1.
  - On start: if len==0 or len>DEPTH, err<=1 and stay in IDLE.
  - Otherwise err<=0, busy<=1, word_cnt<=0, byte_cnt<=0, go to RECV.
- RECV:
  - byte_ready=1 (first asserted the cycle after start is accepted).
  - Transfer occurs only when byte_valid && byte_ready at an edge.
  - Byte k (k=0..3) goes to imem_wdata[8k+7:8k]; byte_cnt increments.
  - After the transfer with byte_cnt==3: byte_cnt<=0, byte_ready<=0, go to WRITE.
  - byte_valid low means hold indefinitely with no timeout.
  - byte_in is ignored while byte_ready==0.
- WRITE:
  - imem_we=1 for exactly one cycle, with imem_addr=word_cnt[ADDR_W-1:0] and imem_wdata stable.
  - Next edge: imem_we<=0. If word_cnt+1==len, go to RUN; else word_cnt++ and go to RECV (byte_ready<=1).
- RUN:
  - cpu_rst=0, done=1, busy=0.
  - cpu_rst falls on the same edge that imem_we falls, so the core's first fetch sees the final word written.
  - start in RUN is validated as in IDLE. If valid: cpu_rst<=1, done<=0, busy<=1, go to RECV (reload). If invalid: err<=1, stay in RUN with the core still running.
- start in RECV or WRITE is ignored; len is not resampled.
- Address range:
  - Maximum load is len==DEPTH, with the last write at address DEPTH-1.
  - word_cnt is ADDR_W+1 bits wide, so the compare with len never wraps.
- Minimum throughput: 5 cycles per word (4 byte transfers + 1 write cycle).
- imem_addr and imem_wdata keep their last values outside WRITE.
- Byte order is little-endian: stream 0x13,0x00,0x01,0x20 produces word 0x20010013.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 and byte_valid=1 -> cpu_rst=1, byte_ready=0, imem_we=0, busy=0, done=0, err=0; no state change.
- Single word: start with len=1, then stream 0x13,0x00,0x01,0x20 back-to-back -> one imem_we pulse, addr 0, wdata 0x20010013. cpu_rst falls and done rises on the edge after the pulse; load takes 5 cycles after byte_ready first rises.
- Back-pressure: len=2 with byte_valid toggled 1,0,0,1,... -> only handshaked bytes are captured; writes go to addr 0 then 1, each with the correct word and exactly one write per word.
- Bad length: start with len=0, then with len=DEPTH+1 -> err=1, no write, byte_ready stays 0, cpu_rst stays 1. A following valid start clears err.
- Mid-load reset: drop rst=0 after 2 bytes of word 3 -> next edge is IDLE with cpu_rst=1. A new load with len=1 writes addr 0.
- Reload from RUN: after a len=1 load completes, pulse start with len=2 -> cpu_rst returns to 1 and done to 0 at the next edge. Two writes follow, then the core is released again. A start pulsed during RECV has no effect.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a little-endian byte program into instruction memory, then releases the core from reset
module imem_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, RUN} state_t;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};
  state_t state_q, state_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0] word_cnt_q, word_cnt_d, len_q, len_d;
  logic [23:0] buf_q, buf_d;
  logic byte_ready_q, byte_ready_d, imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  logic cpu_rst_q, cpu_rst_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic start_ok, xfer, last_word;
  assign start_ok = start && len != '0 && len <= DEPTH;
  assign xfer = byte_valid && byte_ready_q;
  assign last_word = word_cnt_q + ONE == len_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      buf_q        <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      buf_q        <= buf_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: state_d = start_ok ? RECV : state_q;
      RECV:      state_d = xfer && byte_cnt_q == 2'd3 ? WRITE : RECV;
      WRITE:     state_d = last_word ? RUN : RECV;
      default:   state_d = state_q;
    endcase
  end
  // Registered outputs are computed here one cycle ahead of the state they belong to.
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    buf_d        = buf_q;
    byte_ready_d = byte_ready_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_rst_d    = cpu_rst_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    case (state_q)
      IDLE, RUN: if (start) begin
        err_d = !start_ok;
        if (start_ok) begin
          len_d        = len;
          word_cnt_d   = '0;
          byte_cnt_d   = '0;
          byte_ready_d = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          cpu_rst_d    = 1'b1;
        end
      end
      RECV: if (xfer) begin
        buf_d      = {byte_in, buf_q[23:8]};
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          byte_ready_d = 1'b0;
          imem_we_d    = 1'b1;
          imem_addr_d  = word_cnt_q[ADDR_W-1:0];
          imem_wdata_d = {byte_in, buf_q};
        end
      end
      WRITE: if (last_word) begin
        cpu_rst_d = 1'b0;
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end else begin
        word_cnt_d   = word_cnt_q + ONE;
        byte_ready_d = 1'b1;
      end
      default: ;
    endcase
  end
  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule
